// File: rtl/izz_pkg.sv
// izz_pkg: shared constants and the zigzag-to-raster index table for the 8x8 inverse zigzag buffer
package izz_pkg;
  localparam int DEF_DW = 12;
  localparam int BLK_SIZE = 64;
  localparam int IDX_W = 6;
  // Entry k is the row-major position of the k-th coefficient in zigzag scan order.
  localparam logic [IDX_W-1:0] ZZ2RASTER [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
endpackage

// File: rtl/zz2raster_rom.sv
// zz2raster_rom: combinational lookup of zigzag index -> raster index
//   zz_idx     in  IDX_W  position in zigzag scan order
//   raster_idx out IDX_W  matching row-major position
module zz2raster_rom import izz_pkg::*; (
  input  logic [IDX_W-1:0] zz_idx,
  output logic [IDX_W-1:0] raster_idx
);
  assign raster_idx = ZZ2RASTER[zz_idx];
endmodule

// File: rtl/izigzag_buffer.sv
// izigzag_buffer: ping-pong 8x8 buffer that reorders zigzag-scan coefficients into raster order
//   clk, rst_n                      clock, synchronous active-low reset
//   in_data/in_valid/in_ready       zigzag-order input stream
//   out_data/out_valid/out_ready    raster-order output stream
//   out_first/out_last              mark raster index 0 and 63 of each block
module izigzag_buffer import izz_pkg::*; #(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_first,
  output logic          out_last
);
  logic [DW-1:0] mem [2][BLK_SIZE];
  logic [IDX_W-1:0] wr_cnt, rd_cnt, wr_addr;
  logic wr_bank, rd_bank;
  logic [1:0] full;
  logic in_fire, out_fire;
  zz2raster_rom u_rom (.zz_idx(wr_cnt), .raster_idx(wr_addr));
  assign in_ready = ~full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_first = out_valid && rd_cnt == '0;
  assign out_last = out_valid && rd_cnt == '1;
  assign out_data = mem[rd_bank][rd_cnt];
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  always_ff @(posedge clk)
    if (in_fire) mem[wr_bank][wr_addr] <= in_data;
  // The writer only sets a free bank and the reader only clears a full one,
  // so same-cycle set/clear always touch different bits of full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full <= '0;
    end else begin
      if (in_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == '1) begin
          full[wr_bank] <= 1'b1;
          wr_bank <= ~wr_bank;
        end
      end
      if (out_fire) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt == '1) begin
          full[rd_bank] <= 1'b0;
          rd_bank <= ~rd_bank;
        end
      end
    end
  end
endmodule

// File: tb/tb_izigzag_buffer.sv
// tb_izigzag_buffer: randomized self-checking bench with a queue-based reorder model
module tb_izigzag_buffer;
  localparam int DW = 12;
  logic clk = 0, rst_n;
  logic [DW-1:0] in_data, out_data;
  logic in_valid, in_ready, out_valid, out_ready, out_first, out_last;
  izigzag_buffer #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  int zz_pos [64];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] part [64];
  int part_n = 0;
  logic [DW-1:0] rec_q [$];
  int last_idx = -1;
  int cyc = 0, out_cnt = 0, first_cnt = 0, ready_low = 0, first_cyc = 0, last_cyc = 0;
  logic [DW-1:0] src [1280];
  bit fire_in;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, expv, cyc);
    end
  endtask
  // Model: the bank count is ceil(pending outputs / 64); read position follows from queue size.
  always @(negedge clk) begin
    automatic int sz = exp_q.size();
    automatic bit ofire;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      part_n = 0;
    end else begin
      chk("in_ready", in_ready, ((sz + 63) / 64) < 2);
      chk("out_valid", out_valid, sz > 0);
      chk("out_first", out_first, sz > 0 && sz % 64 == 0);
      chk("out_last", out_last, sz % 64 == 1);
      if (sz > 0) chk("out_data", out_data, exp_q[0]);
      if (in_valid && !in_ready) ready_low++;
      ofire = sz > 0 && out_ready;
      if (ofire) begin
        if (out_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        out_cnt++;
        if (out_first) first_cnt++;
        if (out_last) last_idx = rec_q.size();
        rec_q.push_back(out_data);
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        part[zz_pos[part_n]] = in_data;
        part_n++;
        if (part_n == 64) begin
          for (int i = 0; i < 64; i++) exp_q.push_back(part[i]);
          part_n = 0;
        end
      end
    end
  end
  task automatic step();
    @(negedge clk);
    fire_in = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int nin, input int vpct, input int rpct, input bit drain, input int budget);
    automatic int sent = 0;
    automatic int n = 0;
    while ((sent < nin || (drain && exp_q.size() > 0)) && n < budget) begin
      in_valid = sent < nin && $urandom_range(99) < vpct;
      in_data = sent < nin ? src[sent] : '0;
      out_ready = $urandom_range(99) < rpct;
      step();
      if (fire_in) sent++;
      n++;
    end
    in_valid = 0;
    if (n >= budget) begin
      errors++;
      checks++;
      $display("FAIL timeout: sent %0d of %0d, pending %0d", sent, nin, exp_q.size());
    end
  endtask
  task automatic clr_stats();
    out_cnt = 0; first_cnt = 0; ready_low = 0; rec_q.delete(); last_idx = -1;
  endtask
  task automatic fill_rand();
    for (int i = 0; i < 1280; i++) begin
      automatic int r = $urandom_range(7);
      src[i] = r == 0 ? 12'h800 : r == 1 ? 12'h7FF : DW'($urandom);
    end
  endtask
  initial begin
    int row0 [8] = '{0, 1, 5, 6, 14, 15, 27, 28};
    int row1 [8] = '{2, 4, 7, 13, 16, 26, 29, 42};
    int k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0)
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) zz_pos[k++] = r * 8 + (s - r);
      else
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) zz_pos[k++] = r * 8 + (s - r);
    end
    chk("model_zz5", zz_pos[5], 2);
    chk("model_zz28", zz_pos[28], 7);
    chk("model_zz42", zz_pos[42], 15);
    chk("model_zz63", zz_pos[63], 63);
    rst_n = 0; in_valid = 0; out_ready = 0; in_data = 0;
    step(); step();
    rst_n = 1;
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_first", out_first, 0);
    chk("rst_out_last", out_last, 0);
    for (int i = 0; i < 64; i++) src[i] = DW'(i);
    clr_stats();
    drive(64, 100, 100, 1, 500);
    chk("ident_count", rec_q.size(), 64);
    if (rec_q.size() == 64) begin
      for (int i = 0; i < 8; i++) begin
        chk("ident_row0", rec_q[i], row0[i]);
        chk("ident_row1", rec_q[8 + i], row1[i]);
      end
      chk("ident_last_val", rec_q[63], 63);
    end
    chk("ident_last_idx", last_idx, 63);
    fill_rand();
    clr_stats();
    drive(192, 100, 100, 1, 1000);
    chk("b2b_outs", out_cnt, 192);
    chk("b2b_firsts", first_cnt, 3);
    chk("b2b_ready_low", ready_low, 0);
    chk("b2b_span", last_cyc - first_cyc, 191);
    fill_rand();
    clr_stats();
    drive(128, 100, 0, 0, 300);
    in_valid = 1; in_data = 12'h123; out_ready = 0;
    step(); step();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_ready_low_seen", ready_low != 0, 1);
    in_valid = 0;
    repeat (4) begin
      step();
      chk("bp_hold_data", out_data, src[0]);
      chk("bp_hold_first", out_first, 1);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    chk("bp_next_data", out_data, src[1]);
    chk("bp_still_full", in_ready, 0);
    drive(0, 0, 100, 1, 500);
    chk("bp_drained_ready", in_ready, 1);
    fill_rand();
    clr_stats();
    drive(1280, 70, 60, 1, 20000);
    chk("rand_outs", out_cnt, 1280);
    fill_rand();
    drive(64, 100, 0, 0, 200);
    drive(30, 100, 0, 0, 200);
    rst_n = 0; in_valid = 0; out_ready = 1;
    step();
    rst_n = 1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    fill_rand();
    clr_stats();
    drive(64, 100, 100, 1, 500);
    chk("fresh_count", out_cnt, 64);
    if (rec_q.size() == 64) begin
      chk("fresh_0", rec_q[0], src[0]);
      chk("fresh_8", rec_q[8], src[2]);
      chk("fresh_63", rec_q[63], src[63]);
    end
    fill_rand();
    drive(64, 100, 0, 0, 200);
    fill_rand();
    clr_stats();
    drive(128, 100, 100, 1, 1000);
    chk("sim_outs", out_cnt, 192);
    chk("sim_firsts", first_cnt, 3);
    chk("sim_ready_low", ready_low, 0);
    chk("sim_span", last_cyc - first_cyc, 191);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
